voice_allocator: RTL
====================

Name: voice_allocator

Overview:
- Polyphonic voice scheduler between the PS/2 scancode receiver and the sound/display controllers.
- Decodes make/break scancode events and shares NVOICES tone-generator slots among held keys.
- Uses least-recently-allocated voice stealing when all slots are busy.
- Publishes per-slot note codes, active flags and retrigger pulses; the sound path and the keyboard display consume these in parallel.

Parameters:
- NVOICES, 4, number of voice slots (2..8).
- CODE_W, 8, scancode width.
- RANK_W, $clog2(NVOICES), age-rank width per slot.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  reset, asynchronous, active-high.
- code_valid  in  1  one-cycle strobe, code byte valid.
- code  in  CODE_W  received scancode byte.
- voice_active  out  NVOICES  slot i holds a sounding note.
- voice_code  out  NVOICES*CODE_W  slot i note code at bits [i*CODE_W +: CODE_W].
- voice_trig  out  NVOICES  one-cycle pulse: slot i newly (re)assigned.
- steal  out  1  one-cycle pulse: allocation evicted a held note.

Behaviour:
- Reset (async): voice_active=0, voice_code=0, voice_trig=0, steal=0, all ranks=0, prefix FSM to IDLE. Reset mid-sequence drops any pending F0/E0 prefix.
- Prefix FSM, advanced only on code_valid:
  - IDLE: F0 -> BRK; E0 -> EXT; 00 -> IDLE (ignored); other -> MAKE event, stay IDLE.
  - BRK: F0/E0 -> stay BRK (malformed, ignored); 00 -> IDLE; other -> BREAK event, -> IDLE.
  - EXT: F0 -> EXT_BRK; any other code -> discarded, -> IDLE.
  - EXT_BRK: any code -> discarded, -> IDLE.
  - Extended keys never allocate or release voices.
- Latency: event decode and slot search are combinational on the code_valid cycle. All outputs update at the next clk edge (1-cycle latency). voice_trig and steal are high for exactly that one cycle.
- MAKE event, code c:
  - c already in an active slot (typematic repeat): no state change, no trig.
  - Else if any slot is free: use the lowest-index free slot. Set active=1, code=c, rank=0. Every other active slot rank+1. Pulse trig for that slot.
  - Else (all busy): steal the slot with the maximum rank, lowest index on ties. Active slots with rank < stolen rank get +1. Stolen slot gets code=c, rank=0. Pulse trig for it and pulse steal.
- BREAK event, code c:
  - Matching active slot s with rank r: active=0, code kept (display fade), rank=0. Active slots with rank > r get -1.
  - No match: no change (break for a stolen or unknown key is harmless).
- Invariant: ranks of active slots are exactly the distinct set 0..k-1, where k = popcount(voice_active). The testbench checks this every cycle.
- A code never occupies two active slots simultaneously.
- code_valid on consecutive cycles: each event is fully applied before the next. No back-pressure is needed because PS/2 bytes arrive at least ~1 ms apart, but the block must tolerate back-to-back strobes.
- code ignored while code_valid=0.

Decomposition:
- Package synth_pkg: localparams SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_NULL=8'h00; enum for prefix FSM states {IDLE, BRK, EXT, EXT_BRK}.
- One natural sub-module, voice_select: combinational.
  - Inputs: active, codes, ranks, c.
  - Outputs: hit flag/index, free flag/lowest free index, oldest index/rank.
  - Keeps the allocator top as pure sequential update logic.

Test Plan:
- Reset then make 1C (A) -> after 1 cycle: voice_active=0001, slot0 code=1C, voice_trig=0001, steal=0.
- Makes 1C,1B,23,2B then 34 -> final: active=1111, slot0 code=34 (oldest stolen), trig=0001, steal=1; ranks slot0=0, slot1=3, slot2=2, slot3=1.
- Held 1C,1B; sequence F0,1C -> slot0 inactive, slot1 rank 0. Then make 23 -> slot0 reused, code 23, trig=0001.
- Make 1C repeated 5 times (typematic) -> single trig pulse, active=0001, no rank change.
- E0,74 then E0,F0,74, plus F0,55 with 55 not held -> no output change at all; FSM back in IDLE (next make 1C allocates normally).
- Strobe F0, assert reset, then make 1C -> 1C allocated as MAKE (prefix cleared); back-to-back code_valid on 3 consecutive cycles (1C,1B,23) -> three trig pulses on slots 0,1,2 in successive cycles.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and types for the PS/2-driven voice allocator.
// Scancode prefix bytes and the prefix decoder state encoding live here.
package synth_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_NULL  = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } prefix_state_t;

endpackage

// File: rtl/voice_select.sv
// Combinational slot search: key match, lowest free slot and oldest
// (highest-rank, lowest-index) slot for stealing.
module voice_select #(
    parameter int NVOICES = 4,
    parameter int CODE_W  = 8,
    parameter int RANK_W  = $clog2(NVOICES)
) (
    input  logic [NVOICES-1:0]        active,
    input  logic [NVOICES*CODE_W-1:0] codes,
    input  logic [NVOICES*RANK_W-1:0] ranks,
    input  logic [CODE_W-1:0]         c,
    output logic                      hit,
    output logic [RANK_W-1:0]         hit_idx,
    output logic [RANK_W-1:0]         hit_rank,
    output logic                      free,
    output logic [RANK_W-1:0]         free_idx,
    output logic [RANK_W-1:0]         oldest_idx,
    output logic [RANK_W-1:0]         oldest_rank
);

    logic [NVOICES-1:0] match;

    generate
        for (genvar gi = 0; gi < NVOICES; gi++) begin : g_match
            assign match[gi] = active[gi] && (codes[gi*CODE_W +: CODE_W] == c);
        end
    endgenerate

    // Scan downwards so the lowest matching / free index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_rank = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = NVOICES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit      = 1'b1;
                hit_idx  = RANK_W'(i);
                hit_rank = ranks[i*RANK_W +: RANK_W];
            end
            if (!active[i]) begin
                free     = 1'b1;
                free_idx = RANK_W'(i);
            end
        end
    end

    // Strict comparison keeps the lowest index on equal ranks.
    always_comb begin
        oldest_idx  = '0;
        oldest_rank = ranks[RANK_W-1:0];
        for (int i = 1; i < NVOICES; i++) begin
            if (ranks[i*RANK_W +: RANK_W] > oldest_rank) begin
                oldest_idx  = RANK_W'(i);
                oldest_rank = ranks[i*RANK_W +: RANK_W];
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: decodes PS/2 make/break events and assigns
// held keys to NVOICES slots with least-recently-allocated stealing.
module voice_allocator #(
    parameter int NVOICES = 4,
    parameter int CODE_W  = 8,
    parameter int RANK_W  = $clog2(NVOICES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      code_valid,
    input  logic [CODE_W-1:0]         code,
    output logic [NVOICES-1:0]        voice_active,
    output logic [NVOICES*CODE_W-1:0] voice_code,
    output logic [NVOICES-1:0]        voice_trig,
    output logic                      steal
);

    import synth_pkg::*;

    prefix_state_t state_reg, state_next;
    logic          make_ev, break_ev;

    logic [NVOICES-1:0]        active_reg, active_next;
    logic [NVOICES*CODE_W-1:0] code_reg, code_next;
    logic [NVOICES*RANK_W-1:0] rank_reg, rank_next;
    logic [NVOICES-1:0]        trig_reg, trig_next;
    logic                      steal_reg, steal_next;

    logic              hit, free;
    logic [RANK_W-1:0] hit_idx, hit_rank, free_idx, oldest_idx, oldest_rank;

    logic is_break, is_ext, is_null;
    assign is_break = (code == CODE_W'(SC_BREAK));
    assign is_ext   = (code == CODE_W'(SC_EXT));
    assign is_null  = (code == CODE_W'(SC_NULL));

    always_comb begin
        state_next = state_reg;
        make_ev    = 1'b0;
        break_ev   = 1'b0;
        if (code_valid) begin
            case (state_reg)
                IDLE: begin
                    if (is_break)      state_next = BRK;
                    else if (is_ext)   state_next = EXT;
                    else if (!is_null) make_ev    = 1'b1;
                end
                BRK: begin
                    // Stray prefixes after F0 are swallowed; 00 aborts the break.
                    if (is_null) begin
                        state_next = IDLE;
                    end else if (!is_break && !is_ext) begin
                        break_ev   = 1'b1;
                        state_next = IDLE;
                    end
                end
                EXT:     state_next = is_break ? EXT_BRK : IDLE;
                EXT_BRK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    voice_select #(
        .NVOICES (NVOICES),
        .CODE_W  (CODE_W),
        .RANK_W  (RANK_W)
    ) u_select (
        .active      (active_reg),
        .codes       (code_reg),
        .ranks       (rank_reg),
        .c           (code),
        .hit         (hit),
        .hit_idx     (hit_idx),
        .hit_rank    (hit_rank),
        .free        (free),
        .free_idx    (free_idx),
        .oldest_idx  (oldest_idx),
        .oldest_rank (oldest_rank)
    );

    logic do_alloc, do_release;
    assign do_alloc   = make_ev && !hit;
    assign do_release = break_ev && hit;
    assign steal_next = do_alloc && !free;

    generate
        for (genvar gi = 0; gi < NVOICES; gi++) begin : g_slot
            logic              act_cur, act_n, trig_n;
            logic [CODE_W-1:0] code_cur, code_n;
            logic [RANK_W-1:0] rank_cur, rank_n;

            assign act_cur  = active_reg[gi];
            assign code_cur = code_reg[gi*CODE_W +: CODE_W];
            assign rank_cur = rank_reg[gi*RANK_W +: RANK_W];

            always_comb begin
                act_n  = act_cur;
                code_n = code_cur;
                rank_n = rank_cur;
                trig_n = 1'b0;
                if (do_alloc && free) begin
                    if (free_idx == RANK_W'(gi)) begin
                        act_n  = 1'b1;
                        code_n = code;
                        rank_n = '0;
                        trig_n = 1'b1;
                    end else if (act_cur) begin
                        rank_n = rank_cur + RANK_W'(1);
                    end
                end else if (do_alloc) begin
                    if (oldest_idx == RANK_W'(gi)) begin
                        code_n = code;
                        rank_n = '0;
                        trig_n = 1'b1;
                    end else if (rank_cur < oldest_rank) begin
                        rank_n = rank_cur + RANK_W'(1);
                    end
                end else if (do_release) begin
                    // Code is left in place so the display can fade it out.
                    if (hit_idx == RANK_W'(gi)) begin
                        act_n  = 1'b0;
                        rank_n = '0;
                    end else if (act_cur && (rank_cur > hit_rank)) begin
                        rank_n = rank_cur - RANK_W'(1);
                    end
                end
            end

            assign active_next[gi]                = act_n;
            assign code_next[gi*CODE_W +: CODE_W] = code_n;
            assign rank_next[gi*RANK_W +: RANK_W] = rank_n;
            assign trig_next[gi]                  = trig_n;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            active_reg <= '0;
            code_reg   <= '0;
            rank_reg   <= '0;
            trig_reg   <= '0;
            steal_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            active_reg <= active_next;
            code_reg   <= code_next;
            rank_reg   <= rank_next;
            trig_reg   <= trig_next;
            steal_reg  <= steal_next;
        end
    end

    assign voice_active = active_reg;
    assign voice_code   = code_reg;
    assign voice_trig   = trig_reg;
    assign steal        = steal_reg;

endmodule
